ram_csoe_ctrl: RTL and testbench

Request-side controller for one port of the team's chip-select/output-enable synchronous RAMs, which take cs/oe/we with one-cycle registered read data. It accepts read and write commands on a valid/ready request channel, drives the RAM port, and returns read data in order on a valid/ready response channel. It sits between a bus or DMA agent and one RAM port, so agents never track RAM read latency themselves.

---
 rtl/ram_csoe_ctrl.sv | 94 +++++++++
 tb/tb_ram_csoe_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_csoe_ctrl.sv
// ram_csoe_ctrl
// Request-side controller for one port of a cs/oe/we synchronous RAM with
// one-cycle registered read data. Commands arrive on a valid/ready request
// channel and go to the RAM in the cycle they are accepted. Read data comes
// back through a 2-entry in-order FIFO on a valid/ready response channel.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  command handshake (req_ready never depends on req_valid)
//   req_we           1 = write, 0 = read
//   req_addr         command address
//   req_wdata        write data (ignored for reads)
//   rsp_valid/ready  response handshake
//   rsp_rdata        read data, in command order
//   ram_cs/oe/we     RAM strobes, asserted only in the acceptance cycle
//   ram_addr/din     RAM address / write data, zero when idle
//   ram_dout         RAM registered read data, valid the cycle after a read
module ram_csoe_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              ram_cs,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  input  logic [DWIDTH-1:0] ram_dout
);

  logic              fire;
  logic              rd_issue;
  logic              pop;
  logic              pend;
  logic [1:0]        occ;
  logic              wptr;
  logic              rptr;
  logic [2:0]        credit_used;
  logic [DWIDTH-1:0] fifo_mem [2];

  assign rsp_valid = (occ != 2'd0);
  assign pop       = rsp_valid && rsp_ready;

  // Reads in flight plus buffered reads, less the one leaving this cycle.
  // Keeping this below 2 guarantees a FIFO slot for every read issued.
  assign credit_used = {2'b00, pend} + {1'b0, occ} - {2'b00, pop};
  assign req_ready   = !rst && (req_we || (credit_used < 3'd2));

  assign fire     = req_valid && req_ready;
  assign rd_issue = fire && !req_we;

  // Stage p0: RAM issue, combinational in the acceptance cycle
  assign ram_cs   = fire;
  assign ram_we   = fire && req_we;
  assign ram_oe   = rd_issue;
  assign ram_addr = fire ? req_addr : '0;
  assign ram_din  = (fire && req_we) ? req_wdata : '0;

  // Stage p1: pend marks that ram_dout holds read data this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      occ  <= 2'd0;
      wptr <= 1'b0;
      rptr <= 1'b0;
    end else begin
      pend <= rd_issue;
      if (pend) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({pend, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Stage p2: FIFO storage; data needs no reset since rsp_valid gates it
  always_ff @(posedge clk) begin
    if (pend) fifo_mem[wptr] <= ram_dout;
  end

  assign rsp_rdata = fifo_mem[rptr];

endmodule

// File: tb/tb_ram_csoe_ctrl.sv
module tb_ram_csoe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_cs, ram_oe, ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout = 8'h00;
  logic [7:0] mem [16];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_csoe_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural cs/oe/we RAM with registered read data
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else if (ram_oe) ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ready_rd_after_reset", req_ready, 1);
    req_we = 1'b1;
    #1;
    chk("ready_wr_after_reset", req_ready, 1);
    chk("rsp_valid_after_reset", rsp_valid, 0);
    req_we = 1'b0;

    // Write then read back
    cyc();
    drive(1'b1, 1'b1, 4'd3, 8'hA5);
    chk("wb_we_N", ram_we, 1);
    chk("wb_addr_N", ram_addr, 3);
    chk("wb_din_N", ram_din, 8'hA5);
    cyc();
    drive(1'b1, 1'b0, 4'd3, 8'h00);
    chk("wb_we_N1", ram_we, 0);
    chk("wb_oe_N1", ram_oe, 1);
    chk("wb_ready_N1", req_ready, 1);
    cyc();
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    chk("wb_we_N2", ram_we, 0);
    chk("wb_rsp_valid_N2", rsp_valid, 0);
    cyc();
    chk("wb_rsp_valid_N3", rsp_valid, 1);
    chk("wb_rdata_N3", rsp_rdata, 8'hA5);
    cyc();
    chk("wb_rsp_valid_N4", rsp_valid, 0);

    // Preload and streaming reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 8'(i) ^ 8'h5A);
      chk("preload_ready", req_ready, 1);
      cyc();
    end
    for (int k = 0; k < 19; k++) begin
      if (k < 16) drive(1'b1, 1'b0, 4'(k), 8'h00);
      else        drive(1'b0, 1'b0, 4'd0, 8'h00);
      if (k < 16) chk("stream_ready", req_ready, 1);
      if (k >= 2 && k < 18) begin
        chk("stream_rsp_valid", rsp_valid, 1);
        chk("stream_rdata", rsp_rdata, 8'(k - 2) ^ 8'h5A);
      end
      if (k == 18) chk("stream_rsp_valid_end", rsp_valid, 0);
      cyc();
    end

    // Backpressure, then simultaneous pop and accept
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd1, 8'h00);
    chk("bp_rd1_ready", req_ready, 1);
    cyc();
    drive(1'b1, 1'b0, 4'd2, 8'h00);
    chk("bp_rd2_ready", req_ready, 1);
    cyc();
    drive(1'b1, 1'b0, 4'd3, 8'h00);
    chk("bp_rd3_stall", req_ready, 0);
    chk("bp_rd3_no_cs", ram_cs, 0);
    cyc();
    chk("bp_rd3_stall2", req_ready, 0);
    drive(1'b1, 1'b1, 4'd9, 8'h33);
    chk("bp_wr_ready", req_ready, 1);
    chk("bp_wr_we", ram_we, 1);
    cyc();
    drive(1'b1, 1'b0, 4'd3, 8'h00);
    chk("bp_rd3_stall3", req_ready, 0);
    chk("bp_head_valid", rsp_valid, 1);
    chk("bp_head_data", rsp_rdata, 8'h5B);
    cyc();
    chk("bp_head_hold", rsp_rdata, 8'h5B);
    rsp_ready = 1'b1;
    #1;
    chk("pop_accept_ready", req_ready, 1);
    chk("pop_accept_oe", ram_oe, 1);
    cyc();
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    chk("bp_rsp2_valid", rsp_valid, 1);
    chk("bp_rsp2_data", rsp_rdata, 8'h58);
    cyc();
    chk("bp_rsp3_valid", rsp_valid, 1);
    chk("bp_rsp3_data", rsp_rdata, 8'h59);
    cyc();
    chk("bp_drained", rsp_valid, 0);

    // Reset mid-operation
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd4, 8'h00);
    chk("mr_rd4_ready", req_ready, 1);
    cyc();
    drive(1'b1, 1'b0, 4'd5, 8'h00);
    chk("mr_rd5_ready", req_ready, 1);
    cyc();
    drive(1'b1, 1'b0, 4'd6, 8'h00);
    chk("mr_rd6_stall", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ready_rd", req_ready, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_addr", ram_addr, 0);
    req_we = 1'b1;
    req_wdata = 8'hFF;
    #1;
    chk("rst_ready_wr", req_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_din", ram_din, 0);
    cyc();
    rst = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      chk("mr_no_stale_rsp", rsp_valid, 0);
      cyc();
    end
    drive(1'b1, 1'b0, 4'd9, 8'h00);
    chk("mr_rd9_ready", req_ready, 1);
    cyc();
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    chk("mr_rd9_lat1", rsp_valid, 0);
    cyc();
    chk("mr_rd9_valid", rsp_valid, 1);
    chk("mr_rd9_data", rsp_rdata, 8'h33);
    cyc();
    chk("mr_rd9_popped", rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
